copy_sequencer: RTL and testbench

Multi-cycle control FSM for the single-issue core. It fetches each 16-bit instruction, holds it stable for the copy instruction decoder, and sequences the memory source read and the memory destination write over a single shared memory port. It also evaluates the effect condition against the ALU flags and commits register, increment, PC or memory writes. It sits between the memory port, the decoder outputs and the register/ALU datapath.

---
 rtl/copy_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_copy_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/copy_sequencer.sv
// ---------------------------------------------------------------------------
// copy_sequencer
//
// Multi-cycle control FSM for the single-issue core. Each instruction is
// fetched over the shared memory port, held stable for the copy instruction
// decoder, optionally followed by a memory source read (LOAD). The effect
// condition is then evaluated against the ALU flags and the result committed
// to a register, the PC or memory (STORE).
//
// Optional feature macro: SEQ_MEM_TIMEOUT_EN
//   Defined     -> an 8-bit wait counter bounds every memory wait. Reaching
//                  TIMEOUT parks the FSM in FAULT with fault=1 until reset.
//   Not defined -> memory waits are unbounded and fault is tied to 0.
//
// Parameters:
//   RESET_PC  PC (and first fetch address) after reset
//   TIMEOUT   memory-wait limit in cycles (timeout build only)
//
// Ports:
//   clock, reset        clock and asynchronous active-high reset
//   instruction         latched instruction word for the decoder
//   source_memory, destination_mem, destination_pc, destination_reg,
//   pre_increment, effect
//                       decoded controls from the decoder
//   operand_addr        source address for the LOAD read
//   dest_addr           destination address for the STORE write
//   alu_result          value to commit (register, PC or memory)
//   flag_zero,
//   flag_negative       ALU flags used by the effect condition
//   mem_addr, mem_read, mem_write, mem_wdata, mem_rdata, mem_ready
//                       shared memory port; a request completes on the
//                       clock edge where mem_ready is high
//   source_value        latched memory operand
//   pc                  program counter
//   reg_write,
//   inc_write           commit pulses, high only during EXEC
//   fault               sticky memory-timeout flag
// ---------------------------------------------------------------------------
module copy_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] instruction,
  input  logic        source_memory,
  input  logic        destination_mem,
  input  logic        destination_pc,
  input  logic        destination_reg,
  input  logic        pre_increment,
  input  logic [2:0]  effect,
  input  logic [15:0] operand_addr,
  input  logic [15:0] dest_addr,
  input  logic [15:0] alu_result,
  input  logic        flag_zero,
  input  logic        flag_negative,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] source_value,
  output logic [15:0] pc,
  output logic        reg_write,
  output logic        inc_write,
  output logic        fault
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] STORE  = 3'd4;
  localparam logic [2:0] FAULT  = 3'd5;

  logic [2:0]  state;
  logic        commit;
  logic        in_mem_state;
  logic        mem_timeout;
  logic [15:0] pc_inc;

  // Wraps FFFF -> 0000 naturally through the 16-bit width.
  assign pc_inc = pc + 16'd1;

  assign in_mem_state = (state == FETCH) || (state == LOAD) || (state == STORE);

  // Effect condition: effect[2] suppresses the commit entirely, otherwise
  // effect[1:0] picks which flag predicate enables it.
  always_comb begin
    commit = 1'b0;
    if (!effect[2]) begin
      case (effect[1:0])
        2'b00:   commit = flag_zero;
        2'b01:   commit = ~flag_zero;
        2'b10:   commit = flag_negative;
        default: commit = 1'b1;
      endcase
    end
  end

`ifdef SEQ_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;

  assign wait_next = wait_cnt + 8'd1;

  // The counter only runs while a memory state is stalled. Any completed
  // request or any non-memory state clears it, so every FETCH, LOAD and
  // STORE starts counting from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (in_mem_state && !mem_ready) begin
      wait_cnt <= wait_next;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  // Fires on the edge that would bring the wait count up to TIMEOUT, so the
  // FSM is in FAULT right after the TIMEOUT-th stalled cycle.
  assign mem_timeout = in_mem_state && !mem_ready && (wait_next == TIMEOUT);
  assign fault       = (state == FAULT);
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign mem_timeout    = 1'b0;
  assign fault          = 1'b0;
`endif

  // Main sequencer. mem_addr and mem_wdata are loaded on the transition into
  // the memory state that uses them, so they stay stable for the whole wait
  // regardless of what the datapath does meanwhile.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      instruction  <= 16'h0000;
      source_value <= 16'h0000;
      mem_addr     <= RESET_PC;
      mem_wdata    <= 16'h0000;
    end else begin
      case (state)
        FETCH: begin
          if (mem_timeout) begin
            state <= FAULT;
          end else if (mem_ready) begin
            instruction <= mem_rdata;
            state       <= DECODE;
          end
        end

        DECODE: begin
          if (source_memory) begin
            mem_addr <= operand_addr;
            state    <= LOAD;
          end else begin
            state <= EXEC;
          end
        end

        LOAD: begin
          if (mem_timeout) begin
            state <= FAULT;
          end else if (mem_ready) begin
            source_value <= mem_rdata;
            state        <= EXEC;
          end
        end

        EXEC: begin
          // A committed memory destination defers the PC increment to the
          // end of STORE; every other path advances the PC here.
          if (commit && destination_mem) begin
            mem_addr  <= dest_addr;
            mem_wdata <= alu_result;
            state     <= STORE;
          end else begin
            if (commit && destination_pc) begin
              pc       <= alu_result;
              mem_addr <= alu_result;
            end else begin
              pc       <= pc_inc;
              mem_addr <= pc_inc;
            end
            state <= FETCH;
          end
        end

        STORE: begin
          if (mem_timeout) begin
            state <= FAULT;
          end else if (mem_ready) begin
            pc       <= pc_inc;
            mem_addr <= pc_inc;
            state    <= FETCH;
          end
        end

        FAULT: begin
          state <= FAULT;
        end

        default: begin
          state    <= FETCH;
          mem_addr <= pc;
        end
      endcase
    end
  end

  // Strobes are decoded from state. Gating with reset drops a pending
  // request the moment reset rises rather than at the next clock edge.
  assign mem_read  = ~reset && ((state == FETCH) || (state == LOAD));
  assign mem_write = ~reset && (state == STORE);

  // Register writes are suppressed when the commit goes to memory instead.
  assign reg_write = (state == EXEC) && commit && destination_reg && !destination_mem;
  assign inc_write = (state == EXEC) && pre_increment;

endmodule

// File: tb/tb_copy_sequencer.sv
// ---------------------------------------------------------------------------
// tb_copy_sequencer
//
// Directed testbench for copy_sequencer. The bench plays both the decoder
// (driving the decoded controls directly) and the memory (mem_rdata and
// mem_ready). Expected values are hand-computed per instruction.
// ---------------------------------------------------------------------------
module tb_copy_sequencer;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clock;
  logic        reset;
  logic [15:0] instruction;
  logic        source_memory;
  logic        destination_mem;
  logic        destination_pc;
  logic        destination_reg;
  logic        pre_increment;
  logic [2:0]  effect;
  logic [15:0] operand_addr;
  logic [15:0] dest_addr;
  logic [15:0] alu_result;
  logic        flag_zero;
  logic        flag_negative;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] source_value;
  logic [15:0] pc;
  logic        reg_write;
  logic        inc_write;
  logic        fault;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] eff;
    logic       fz;
    logic       fn;
    logic       exp_commit;
  } cond_vec_t;

  cond_vec_t cond_vecs [6];

  copy_sequencer #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (8'd4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .instruction     (instruction),
    .source_memory   (source_memory),
    .destination_mem (destination_mem),
    .destination_pc  (destination_pc),
    .destination_reg (destination_reg),
    .pre_increment   (pre_increment),
    .effect          (effect),
    .operand_addr    (operand_addr),
    .dest_addr       (dest_addr),
    .alu_result      (alu_result),
    .flag_zero       (flag_zero),
    .flag_negative   (flag_negative),
    .mem_addr        (mem_addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ready       (mem_ready),
    .source_value    (source_value),
    .pc              (pc),
    .reg_write       (reg_write),
    .inc_write       (inc_write),
    .fault           (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance one clock and sample 2 time units after the rising edge.
  task automatic nextCycle();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic smem, input logic dmem, input logic dpc,
                               input logic dreg, input logic pinc, input logic [2:0] eff);
    source_memory   = smem;
    destination_mem = dmem;
    destination_pc  = dpc;
    destination_reg = dreg;
    pre_increment   = pinc;
    effect          = eff;
  endtask

  initial begin
    logic [15:0] exp_pc;

    cond_vecs[0] = '{eff: 3'b100, fz: 1'b1, fn: 1'b1, exp_commit: 1'b0};
    cond_vecs[1] = '{eff: 3'b001, fz: 1'b0, fn: 1'b0, exp_commit: 1'b1};
    cond_vecs[2] = '{eff: 3'b001, fz: 1'b1, fn: 1'b0, exp_commit: 1'b0};
    cond_vecs[3] = '{eff: 3'b010, fz: 1'b0, fn: 1'b1, exp_commit: 1'b1};
    cond_vecs[4] = '{eff: 3'b010, fz: 1'b1, fn: 1'b0, exp_commit: 1'b0};
    cond_vecs[5] = '{eff: 3'b111, fz: 1'b1, fn: 1'b1, exp_commit: 1'b0};

    reset         = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    operand_addr  = 16'h0000;
    dest_addr     = 16'h0000;
    alu_result    = 16'h0000;
    flag_zero     = 1'b0;
    flag_negative = 1'b0;
    mem_rdata     = 16'h1111;
    mem_ready     = 1'b1;

    // Reset state
    repeat (2) nextCycle();
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_addr", mem_addr, RESET_PC);
    checkOutput("rst_read", {15'd0, mem_read}, 16'd0);
    checkOutput("rst_write", {15'd0, mem_write}, 16'd0);
    checkOutput("rst_instr", instruction, 16'h0000);
    checkOutput("rst_srcval", source_value, 16'h0000);
    checkOutput("rst_wdata", mem_wdata, 16'h0000);
    checkOutput("rst_fault", {15'd0, fault}, 16'd0);

    // Register-to-register copy, effect=11: 3 cycles
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011);
    #1;
    checkOutput("t1_fetch_read", {15'd0, mem_read}, 16'd1);
    checkOutput("t1_fetch_addr", mem_addr, 16'h0000);
    nextCycle();
    checkOutput("t1_instr", instruction, 16'h1111);
    checkOutput("t1_dec_read", {15'd0, mem_read}, 16'd0);
    checkOutput("t1_dec_regw", {15'd0, reg_write}, 16'd0);
    nextCycle();
    checkOutput("t1_exec_regw", {15'd0, reg_write}, 16'd1);
    checkOutput("t1_exec_incw", {15'd0, inc_write}, 16'd0);
    nextCycle();
    checkOutput("t1_fetch2_read", {15'd0, mem_read}, 16'd1);
    checkOutput("t1_fetch2_addr", mem_addr, 16'h0001);
    checkOutput("t1_regw_done", {15'd0, reg_write}, 16'd0);
    exp_pc = 16'h0001;

    // Memory source: 4 cycles, source_value latched from LOAD
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011);
    operand_addr = 16'h1234;
    mem_rdata    = 16'hABCD;
    nextCycle();
    nextCycle();
    checkOutput("t2_load_read", {15'd0, mem_read}, 16'd1);
    checkOutput("t2_load_addr", mem_addr, 16'h1234);
    nextCycle();
    checkOutput("t2_srcval", source_value, 16'hABCD);
    checkOutput("t2_exec_regw", {15'd0, reg_write}, 16'd1);
    nextCycle();
    exp_pc = exp_pc + 16'd1;
    checkOutput("t2_pc", pc, exp_pc);
    checkOutput("t2_fetch_addr", mem_addr, exp_pc);

    // Memory destination, effect=00 with flag_zero=1: one write cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    flag_zero  = 1'b1;
    alu_result = 16'h5A5A;
    dest_addr  = 16'h2000;
    nextCycle();
    nextCycle();
    checkOutput("t3_exec_incw", {15'd0, inc_write}, 16'd1);
    checkOutput("t3_exec_regw", {15'd0, reg_write}, 16'd0);
    checkOutput("t3_exec_write", {15'd0, mem_write}, 16'd0);
    nextCycle();
    checkOutput("t3_store_write", {15'd0, mem_write}, 16'd1);
    checkOutput("t3_store_read", {15'd0, mem_read}, 16'd0);
    checkOutput("t3_store_addr", mem_addr, 16'h2000);
    checkOutput("t3_store_data", mem_wdata, 16'h5A5A);
    checkOutput("t3_store_pc", pc, exp_pc);
    nextCycle();
    exp_pc = exp_pc + 16'd1;
    checkOutput("t3_done_write", {15'd0, mem_write}, 16'd0);
    checkOutput("t3_pc", pc, exp_pc);

    // Same instruction with flag_zero=0: no write, pc+1 after 3 cycles
    flag_zero = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("t3b_exec_incw", {15'd0, inc_write}, 16'd1);
    checkOutput("t3b_exec_write", {15'd0, mem_write}, 16'd0);
    nextCycle();
    exp_pc = exp_pc + 16'd1;
    checkOutput("t3b_write", {15'd0, mem_write}, 16'd0);
    checkOutput("t3b_read", {15'd0, mem_read}, 16'd1);
    checkOutput("t3b_pc", pc, exp_pc);

    // Effect-condition table on register copies
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cond_vecs[i].eff);
      flag_zero     = cond_vecs[i].fz;
      flag_negative = cond_vecs[i].fn;
      nextCycle();
      nextCycle();
      checkOutput($sformatf("cond%0d_regw", i), {15'd0, reg_write}, {15'd0, cond_vecs[i].exp_commit});
      nextCycle();
      exp_pc = exp_pc + 16'd1;
      checkOutput($sformatf("cond%0d_pc", i), pc, exp_pc);
    end

    // FETCH wait: address and strobe held for 3 stalled cycles, then reset
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("wait%0d_read", i), {15'd0, mem_read}, 16'd1);
      checkOutput($sformatf("wait%0d_addr", i), mem_addr, exp_pc);
      nextCycle();
    end
    reset = 1'b1;
    #1;
    checkOutput("wait_rst_read", {15'd0, mem_read}, 16'd0);
    checkOutput("wait_rst_pc", pc, RESET_PC);
    nextCycle();
    reset     = 1'b0;
    mem_ready = 1'b1;
    #1;
    checkOutput("post_rst_read", {15'd0, mem_read}, 16'd1);

    // Jump to FFFF, then a register copy wraps the PC to 0000
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b011);
    alu_result = 16'hFFFF;
    nextCycle();
    nextCycle();
    checkOutput("t4_exec_regw", {15'd0, reg_write}, 16'd0);
    nextCycle();
    checkOutput("t4_pc_jump", pc, 16'hFFFF);
    checkOutput("t4_addr_jump", mem_addr, 16'hFFFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("t4_pc_wrap", pc, 16'h0000);
    checkOutput("t4_addr_wrap", mem_addr, 16'h0000);

    // STORE stalled with mem_ready low
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011);
    dest_addr  = 16'h3000;
    alu_result = 16'h1357;
    nextCycle();
    nextCycle();
    mem_ready = 1'b0;
    nextCycle();
    checkOutput("t6_store_write", {15'd0, mem_write}, 16'd1);
    checkOutput("t6_store_addr", mem_addr, 16'h3000);
    checkOutput("t6_store_data", mem_wdata, 16'h1357);
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
`ifdef SEQ_MEM_TIMEOUT_EN
      checkOutput($sformatf("t6_wait%0d_fault", i), {15'd0, fault}, (i == 4) ? 16'd1 : 16'd0);
      checkOutput($sformatf("t6_wait%0d_write", i), {15'd0, mem_write}, (i == 4) ? 16'd0 : 16'd1);
`else
      checkOutput($sformatf("t6_wait%0d_fault", i), {15'd0, fault}, 16'd0);
      checkOutput($sformatf("t6_wait%0d_write", i), {15'd0, mem_write}, 16'd1);
`endif
      checkOutput($sformatf("t6_wait%0d_read", i), {15'd0, mem_read}, 16'd0);
    end
    mem_ready = 1'b1;
    nextCycle();
`ifdef SEQ_MEM_TIMEOUT_EN
    checkOutput("t6_fault_sticky", {15'd0, fault}, 16'd1);
    checkOutput("t6_fault_pc", pc, 16'h0000);
    checkOutput("t6_fault_read", {15'd0, mem_read}, 16'd0);
`else
    checkOutput("t6_nofault", {15'd0, fault}, 16'd0);
    checkOutput("t6_store_done_pc", pc, 16'h0001);
    checkOutput("t6_store_done_read", {15'd0, mem_read}, 16'd1);
`endif
    checkOutput("t6_after_write", {15'd0, mem_write}, 16'd0);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_fault", {15'd0, fault}, 16'd0);
    checkOutput("t6_rst_pc", pc, RESET_PC);
    nextCycle();
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
